ovi_bridge: RTL and testbench

OVI (Open Vector Interface) adapter between the scalar core model and the vector unit. It performs the following functions:
- converts core vector-instruction requests into OVI issue/dispatch transactions;
- allocates scoreboard IDs and tracks VPU issue credits;
- returns completions to the core;
- closes memory-op, store and mask/index handshakes so the VPU never stalls on memory.

It sits between the core automaton and `vpu_core` at simulation top level.

---
 rtl/ovi_bridge_if.sv | 32 +++
 rtl/ovi_bridge.sv | 142 ++++++++++++++
 tb/tb_ovi_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ovi_bridge_if.sv
// Core/VPU-facing bus bundle for the OVI bridge; field layouts are documented on ovi_bridge.
// The slave modport is the bridge side, the master modport is the core/VPU environment side.
interface ovi_bridge_if;
    logic [136:0] CORE_ISSUE;
    logic         CORE_HALT;
    logic [90:0]  CORE_COMPLETED;
    logic [141:0] VPU_ISSUE;
    logic         VPU_ISSUE_CREDIT;
    logic [6:0]   VPU_DISPATCH;
    logic [90:0]  VPU_COMPLETED;
    logic         VPU_SYNC_START;
    logic [20:0]  VPU_MEMOP;
    logic [611:0] VPU_LOAD;
    logic [512:0] VPU_STORE;
    logic         VPU_STORE_CREDIT;
    logic [66:0]  VPU_MASK_IDX;
    logic         VPU_MASK_IDX_CREDIT;

    modport slave (
        input  CORE_ISSUE, VPU_ISSUE_CREDIT, VPU_COMPLETED, VPU_SYNC_START,
               VPU_STORE, VPU_MASK_IDX,
        output CORE_HALT, CORE_COMPLETED, VPU_ISSUE, VPU_DISPATCH, VPU_MEMOP,
               VPU_LOAD, VPU_STORE_CREDIT, VPU_MASK_IDX_CREDIT
    );

    modport master (
        output CORE_ISSUE, VPU_ISSUE_CREDIT, VPU_COMPLETED, VPU_SYNC_START,
               VPU_STORE, VPU_MASK_IDX,
        input  CORE_HALT, CORE_COMPLETED, VPU_ISSUE, VPU_DISPATCH, VPU_MEMOP,
               VPU_LOAD, VPU_STORE_CREDIT, VPU_MASK_IDX_CREDIT
    );
endinterface

// File: rtl/ovi_bridge.sv
// OVI adapter: core issue -> VPU issue/dispatch, completion return, memory/store/mask handshake closure.
// Issue 1 cycle, dispatch 2, all other responses 1; core is halted on no credits, full scoreboard or full memq.
module ovi_bridge #(
    parameter int INIT_ISSUE_CREDITS = 0,
    parameter int SB_DEPTH           = 32,
    parameter int MEMQ_DEPTH         = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    ovi_bridge_if.slave bus
);
    localparam int PTR_W = (MEMQ_DEPTH > 1) ? $clog2(MEMQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(MEMQ_DEPTH + 1);

    typedef struct packed {
        logic        vld;
        logic [31:0] instr;
        logic [63:0] scalar_opnd;
        logic [39:0] vcsr;
    } core_issue_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] instr;
        logic [4:0]  sb_id;
        logic [63:0] scalar_opnd;
        logic [39:0] vcsr;
    } vpu_issue_t;

    core_issue_t iss;
    vpu_issue_t  issue_q;

    logic [5:0]       credits;
    logic [5:0]       outstanding;
    logic [4:0]       next_sb;
    logic [4:0]       memq [MEMQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] memq_cnt;

    logic        disp_vld;
    logic [4:0]  disp_sb;
    logic [90:0] cmp_q;
    logic        memop_vld;
    logic [4:0]  memop_sb;
    logic        st_credit;
    logic        mk_credit;

    logic core_halt, accept, push, pop, memq_empty, cmp_vld, cmp_dec;
    logic unused_bits;

    assign iss        = bus.CORE_ISSUE;
    assign memq_empty = (memq_cnt == '0);
    assign core_halt  = (credits == 6'd0) || (outstanding == 6'(SB_DEPTH))
                     || (memq_cnt == CNT_W'(MEMQ_DEPTH));
    assign accept     = iss.vld && !core_halt && !RESET;
    assign push       = accept && ((iss.instr[6:0] == 7'b0000111) || (iss.instr[6:0] == 7'b0100111));
    assign pop        = bus.VPU_SYNC_START && !memq_empty;
    assign cmp_vld    = bus.VPU_COMPLETED[90];
    // Guards against a stray completion driving outstanding below zero.
    assign cmp_dec    = cmp_vld && ((outstanding != 6'd0) || accept);
    assign unused_bits = ^{bus.VPU_STORE[511:0], bus.VPU_MASK_IDX[65:0]};

    always_ff @(posedge CLK) begin
        if (push) begin
            memq[wr_ptr] <= next_sb;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            credits     <= 6'(INIT_ISSUE_CREDITS);
            outstanding <= '0;
            next_sb     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            memq_cnt    <= '0;
            issue_q     <= '0;
            disp_vld    <= 1'b0;
            disp_sb     <= '0;
            cmp_q       <= '0;
            memop_vld   <= 1'b0;
            memop_sb    <= '0;
            st_credit   <= 1'b0;
            mk_credit   <= 1'b0;
        end else begin
            case ({accept, bus.VPU_ISSUE_CREDIT})
                2'b10:   credits <= credits - 6'd1;
                2'b01:   credits <= (credits == 6'd63) ? credits : credits + 6'd1;
                default: credits <= credits;
            endcase

            if (accept && !cmp_dec) begin
                outstanding <= outstanding + 6'd1;
            end else if (!accept && cmp_dec) begin
                outstanding <= outstanding - 6'd1;
            end

            issue_q.vld <= accept;
            if (accept) begin
                issue_q.instr       <= iss.instr;
                issue_q.sb_id       <= next_sb;
                issue_q.scalar_opnd <= iss.scalar_opnd;
                issue_q.vcsr        <= iss.vcsr;
                next_sb             <= next_sb + 5'd1;
            end

            // Everything is non-speculative, so each issue is followed by a senior dispatch.
            disp_vld <= issue_q.vld;
            disp_sb  <= issue_q.vld ? issue_q.sb_id : 5'd0;

            cmp_q <= cmp_vld ? bus.VPU_COMPLETED : 91'd0;

            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(MEMQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MEMQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                memq_cnt <= memq_cnt + 1'b1;
            end else if (pop && !push) begin
                memq_cnt <= memq_cnt - 1'b1;
            end

            memop_vld <= bus.VPU_SYNC_START;
            memop_sb  <= pop ? memq[rd_ptr] : 5'd0;

            st_credit <= bus.VPU_STORE[512];
            mk_credit <= bus.VPU_MASK_IDX[66];
        end
    end

    assign bus.CORE_HALT           = core_halt;
    assign bus.VPU_ISSUE           = issue_q;
    assign bus.VPU_DISPATCH        = {1'b0, disp_vld, disp_sb};
    assign bus.CORE_COMPLETED      = cmp_q;
    assign bus.VPU_MEMOP           = {memop_vld, memop_sb, 15'd0};
    assign bus.VPU_LOAD            = '0;
    assign bus.VPU_STORE_CREDIT    = st_credit;
    assign bus.VPU_MASK_IDX_CREDIT = mk_credit;
endmodule

// File: tb/tb_ovi_bridge.sv
// Directed + randomized check of ovi_bridge against a queue/counter reference model.
module tb_ovi_bridge;
    localparam logic [31:0] VADD  = 32'h0200_8057;
    localparam logic [31:0] VLOAD = 32'h0200_8007;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    ovi_bridge_if bus ();
    ovi_bridge dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_credits = 0;
    int m_out = 0;
    int m_sb = 0;
    int memq[$];
    bit m_prev_acc = 1'b0;
    int m_prev_sb = 0;

    task automatic chk(input string tag, input logic [611:0] obs, input logic [611:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic idle();
        bus.CORE_ISSUE       = '0;
        bus.VPU_ISSUE_CREDIT = 1'b0;
        bus.VPU_COMPLETED    = '0;
        bus.VPU_SYNC_START   = 1'b0;
        bus.VPU_STORE        = '0;
        bus.VPU_MASK_IDX     = '0;
    endtask

    task automatic issue_in(input logic [31:0] instr);
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        bus.CORE_ISSUE = {1'b1, instr, a, b[39:0]};
    endtask

    function automatic logic [90:0] mk_cmp(input logic [4:0] sb, input logic [4:0] ff, input logic [63:0] dest);
        return {1'b1, sb, ff, 1'b0, dest, 14'd0, 1'b0};
    endfunction

    // One clock: check halt pre-edge, step the model, check registered outputs after the edge.
    task automatic cycle();
        logic        halt_e;
        logic        acc;
        logic [141:0] e_iss;
        logic [90:0] cmp_in;
        logic        sync_in, st_in, mk_in, prev_acc;
        int          head, prev_sb;
        if (RESET) begin
            @(posedge CLK); #1;
            chk("rst_issue", bus.VPU_ISSUE, '0);
            chk("rst_dispatch", bus.VPU_DISPATCH, '0);
            chk("rst_completed", bus.CORE_COMPLETED, '0);
            chk("rst_memop", bus.VPU_MEMOP, '0);
            chk("rst_load", bus.VPU_LOAD, '0);
            chk("rst_st_credit", bus.VPU_STORE_CREDIT, 1'b0);
            chk("rst_mk_credit", bus.VPU_MASK_IDX_CREDIT, 1'b0);
            chk("rst_halt", bus.CORE_HALT, 1'b1);
            m_credits = 0; m_out = 0; m_sb = 0; memq.delete();
            m_prev_acc = 1'b0; m_prev_sb = 0;
            return;
        end
        halt_e = (m_credits == 0) || (m_out == 32) || (memq.size() == 8);
        chk("halt", bus.CORE_HALT, halt_e);
        acc     = bus.CORE_ISSUE[136] && !halt_e;
        e_iss   = {1'b1, bus.CORE_ISSUE[135:104], 5'(m_sb), bus.CORE_ISSUE[103:0]};
        cmp_in  = bus.VPU_COMPLETED;
        sync_in = bus.VPU_SYNC_START;
        st_in   = bus.VPU_STORE[512];
        mk_in   = bus.VPU_MASK_IDX[66];
        head = 0;
        if (sync_in && memq.size() > 0) head = memq.pop_front();
        if (acc && (e_iss[115:109] == 7'h07 || e_iss[115:109] == 7'h27)) memq.push_back(m_sb);
        prev_acc = m_prev_acc; prev_sb = m_prev_sb;
        m_prev_acc = acc; m_prev_sb = m_sb;
        m_credits = m_credits + (bus.VPU_ISSUE_CREDIT ? 1 : 0) - (acc ? 1 : 0);
        m_out = m_out + (acc ? 1 : 0) - (cmp_in[90] ? 1 : 0);
        if (acc) m_sb = (m_sb + 1) % 32;
        @(posedge CLK); #1;
        chk("issue_vld", bus.VPU_ISSUE[141], acc);
        if (acc) chk("issue", bus.VPU_ISSUE, e_iss);
        if (prev_acc) chk("dispatch", bus.VPU_DISPATCH, {2'b01, 5'(prev_sb)});
        else          chk("dispatch_idle", bus.VPU_DISPATCH[6:5], 2'b00);
        if (cmp_in[90]) chk("completed", bus.CORE_COMPLETED, cmp_in);
        else            chk("completed_idle", bus.CORE_COMPLETED[90], 1'b0);
        if (sync_in) chk("memop", bus.VPU_MEMOP, {1'b1, 5'(head), 15'd0});
        else         chk("memop_idle", bus.VPU_MEMOP[20], 1'b0);
        chk("st_credit", bus.VPU_STORE_CREDIT, st_in);
        chk("mk_credit", bus.VPU_MASK_IDX_CREDIT, mk_in);
        chk("load_zero", bus.VPU_LOAD, '0);
    endtask

    initial begin
        int st_pulses;
        int mk_pulses;
        logic [31:0] r;
        logic [2:0]  pick;
        logic [95:0] cr;
        idle();
        RESET = 1'b1;
        issue_in(VADD);
        cycle();
        cycle();
        RESET = 1'b0;

        // No credits: the presented issue must stay blocked.
        cycle();
        chk("no_issue_when_halted", bus.VPU_ISSUE[141], 1'b0);
        idle();
        bus.VPU_ISSUE_CREDIT = 1'b1;
        cycle();
        chk("halt_clears_after_credit", bus.CORE_HALT, 1'b0);
        cycle();
        cycle();
        idle();

        // Three back-to-back vadds on three credits.
        issue_in(VADD);
        cycle();
        chk("b2b_sb0", bus.VPU_ISSUE[108:104], 5'd0);
        issue_in(VADD);
        cycle();
        chk("b2b_sb1", bus.VPU_ISSUE[108:104], 5'd1);
        chk("b2b_disp0", bus.VPU_DISPATCH, 7'b0100000);
        issue_in(VADD);
        cycle();
        chk("b2b_sb2", bus.VPU_ISSUE[108:104], 5'd2);
        chk("b2b_disp1", bus.VPU_DISPATCH, 7'b0100001);
        chk("b2b_halt", bus.CORE_HALT, 1'b1);
        idle();
        cycle();
        chk("b2b_disp2", bus.VPU_DISPATCH, 7'b0100010);

        // Completion forwarding.
        bus.VPU_COMPLETED = mk_cmp(5'd1, 5'b00001, 64'h1234);
        cycle();
        chk("cmp_fwd", bus.CORE_COMPLETED, mk_cmp(5'd1, 5'b00001, 64'h1234));
        idle();

        // Credit+accept, then completion+accept (the latter a load as sb 4).
        bus.VPU_ISSUE_CREDIT = 1'b1;
        cycle();
        issue_in(VADD);
        bus.VPU_ISSUE_CREDIT = 1'b1;
        cycle();
        chk("sim_credit_sb3", bus.VPU_ISSUE[108:104], 5'd3);
        chk("sim_credit_unchanged", bus.CORE_HALT, 1'b0);
        idle();
        issue_in(VLOAD);
        bus.VPU_COMPLETED = mk_cmp(5'd0, 5'd0, 64'hdead_beef);
        cycle();
        chk("load_sb4", bus.VPU_ISSUE[108:104], 5'd4);
        chk("halt_credits_spent", bus.CORE_HALT, 1'b1);
        idle();

        // Memory op: head sb 4, then an empty pop.
        bus.VPU_SYNC_START = 1'b1;
        cycle();
        chk("memop_sb4", bus.VPU_MEMOP, {1'b1, 5'd4, 15'd0});
        cycle();
        chk("memop_empty", bus.VPU_MEMOP, {1'b1, 5'd0, 15'd0});
        idle();

        // Store and mask/index beats.
        st_pulses = 0;
        mk_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 4) begin
                bus.VPU_STORE    = {1'b1, {16{$urandom}}};
                bus.VPU_MASK_IDX = {1'b1, 1'b0, $urandom, $urandom, 1'b0};
            end
            cycle();
            if (bus.VPU_STORE_CREDIT) st_pulses++;
            if (bus.VPU_MASK_IDX_CREDIT) mk_pulses++;
        end
        chk("store_credit_count", 32'(st_pulses), 32'd4);
        chk("mask_credit_count", 32'(mk_pulses), 32'd4);
        idle();

        // sb_id wrap: hold credits and outstanding steady with paired pulses.
        bus.VPU_ISSUE_CREDIT = 1'b1;
        cycle();
        for (int i = 0; i < 28; i++) begin
            issue_in(VADD);
            bus.VPU_ISSUE_CREDIT = 1'b1;
            bus.VPU_COMPLETED = mk_cmp(5'(i), 5'(i), 64'(i));
            cycle();
            if (i == 26) chk("wrap_sb31", bus.VPU_ISSUE[108:104], 5'd31);
            if (i == 27) chk("wrap_sb0", bus.VPU_ISSUE[108:104], 5'd0);
        end
        idle();

        // Reset mid-operation drops the in-flight completion.
        issue_in(VADD);
        bus.VPU_COMPLETED = mk_cmp(5'd7, 5'd3, 64'h55);
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        idle();
        cycle();
        chk("post_rst_no_cmp", bus.CORE_COMPLETED[90], 1'b0);
        chk("post_rst_halt", bus.CORE_HALT, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            idle();
            if ($urandom_range(2, 0) != 0) begin
                r = $urandom;
                pick = 3'($urandom_range(4, 0));
                r[6:0] = (pick == 3'd0) ? 7'h07 : (pick == 3'd1) ? 7'h27 : 7'h57;
                issue_in(r);
            end
            bus.VPU_ISSUE_CREDIT = (m_credits < 60) && ($urandom_range(1, 0) == 1);
            if (m_out > 0 && $urandom_range(2, 0) == 0) begin
                cr = {$urandom, $urandom, $urandom};
                cr[90] = 1'b1;
                bus.VPU_COMPLETED = cr[90:0];
            end
            bus.VPU_SYNC_START = ($urandom_range(3, 0) == 0);
            if ($urandom_range(1, 0) == 1) bus.VPU_STORE = {1'b1, {16{$urandom}}};
            if ($urandom_range(1, 0) == 1) bus.VPU_MASK_IDX = {1'b1, 2'b00, $urandom, $urandom};
            cycle();
        end
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
